// File: rtl/l1_set_assoc_if.sv
// Core-side and memory-side bus bundles for the l1_set_assoc cache.
// The master modport belongs to whoever issues requests on that bus.
interface l1_core_if;
  logic        req_valid;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        should_write;
  logic        should_cache;
  logic [31:0] output_data;
  logic        ready;
  logic        hit;

  modport master (output req_valid, address, input_data, should_write, should_cache,
                  input  output_data, ready, hit);
  modport slave  (input  req_valid, address, input_data, should_write, should_cache,
                  output output_data, ready, hit);
endinterface

interface l1_mem_if;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  modport master (output mem_request, mem_write, mem_address, mem_write_data,
                  input  mem_read_data, mem_ready);
  modport slave  (input  mem_request, mem_write, mem_address, mem_write_data,
                  output mem_read_data, mem_ready);
endinterface

// File: rtl/l1_set_assoc.sv
// N-way set-associative L1 cache: read-allocate with burst refill, write-through
// without allocation, uncached bypass, round-robin replacement per set.
module l1_set_assoc #(
  parameter int WAYS           = 2,
  parameter int SETS           = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic      clock,
  input  logic      reset,
  l1_core_if.slave  core,
  l1_mem_if.master  mem
);

  localparam int OB  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 0;
  localparam int IB  = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int OBW = (OB > 0) ? OB : 1;
  localparam int IBW = (IB > 0) ? IB : 1;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TW  = 30 - OB - IB;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_REFILL, S_BYPASS, S_WRITE, S_RESPOND
  } state_e;

  state_e          state_q, state_d;
  logic [29:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            write_q, cache_q, hit_q, evict_q;
  logic [WW-1:0]   way_q;
  logic [OBW-1:0]  k_q, k_d;

  logic            ready_q, ready_d, hit_rsp_q, hit_rsp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mreq_q, mreq_d, mwr_q, mwr_d;
  logic [31:0]     maddr_q, maddr_d, mwdata_q, mwdata_d;

  logic [31:0]     data_q  [WAYS][SETS][WORDS_PER_LINE];
  logic [TW-1:0]   tag_q   [WAYS][SETS];
  logic            valid_q [SETS][WAYS];
  logic [WW-1:0]   rr_q    [SETS];

  logic [OBW-1:0]  off;
  logic [IBW-1:0]  idx;
  logic [TW-1:0]   tag;
  logic [29:0]     line_base;
  logic            hit_any, free_found, mem_done, last_word;
  logic [WW-1:0]   hit_way, victim, rr_next;

  assign off       = OBW'(addr_q & 30'(WORDS_PER_LINE - 1));
  assign idx       = IBW'((addr_q >> OB) & 30'(SETS - 1));
  assign tag       = TW'(addr_q >> (OB + IB));
  assign line_base = addr_q & ~30'(WORDS_PER_LINE - 1);
  assign mem_done  = mreq_q & mem.mem_ready;
  assign last_word = (k_q == OBW'(WORDS_PER_LINE - 1));
  assign rr_next   = WW'((int'(rr_q[idx]) + 1) % WAYS);

  assign core.ready       = ready_q;
  assign core.hit         = hit_rsp_q;
  assign core.output_data = rdata_q;
  assign mem.mem_request    = mreq_q;
  assign mem.mem_write      = mwr_q;
  assign mem.mem_address    = maddr_q;
  assign mem.mem_write_data = mwdata_q;

  // Tag match and victim choice for the latched address; the victim is the
  // lowest invalid way, falling back to the set's round-robin pointer.
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    victim     = rr_q[idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][WW'(w)] && tag_q[WW'(w)][idx] == tag) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (!free_found && !valid_q[idx][WW'(w)]) begin
        free_found = 1'b1;
        victim     = WW'(w);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ready_d   = 1'b0;
    hit_rsp_d = 1'b0;
    rdata_d   = '0;
    mreq_d    = mreq_q;
    mwr_d     = mwr_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    unique case (state_q)
      S_IDLE: if (core.req_valid) state_d = S_COMPARE;
      S_COMPARE: begin
        if (write_q) begin
          state_d  = S_WRITE;
          mreq_d   = 1'b1;
          mwr_d    = 1'b1;
          maddr_d  = {addr_q, 2'b00};
          mwdata_d = wdata_q;
        end else if (!cache_q) begin
          state_d = S_BYPASS;
          mreq_d  = 1'b1;
          mwr_d   = 1'b0;
          maddr_d = {addr_q, 2'b00};
        end else if (hit_any) begin
          state_d   = S_RESPOND;
          ready_d   = 1'b1;
          hit_rsp_d = 1'b1;
          rdata_d   = data_q[hit_way][idx][off];
        end else begin
          state_d = S_REFILL;
          k_d     = '0;
          mreq_d  = 1'b1;
          mwr_d   = 1'b0;
          maddr_d = {line_base, 2'b00};
        end
      end
      S_REFILL: if (mem_done) begin
        if (last_word) begin
          state_d = S_RESPOND;
          mreq_d  = 1'b0;
          ready_d = 1'b1;
          // The requested word may be the one arriving on this very edge.
          rdata_d = (k_q == off) ? mem.mem_read_data : data_q[way_q][idx][off];
        end else begin
          k_d     = k_q + 1'b1;
          maddr_d = {line_base | 30'(k_q + 1'b1), 2'b00};
        end
      end
      S_BYPASS: if (mem_done) begin
        state_d = S_RESPOND;
        mreq_d  = 1'b0;
        ready_d = 1'b1;
        rdata_d = mem.mem_read_data;
      end
      S_WRITE: if (mem_done) begin
        state_d   = S_RESPOND;
        mreq_d    = 1'b0;
        mwr_d     = 1'b0;
        ready_d   = 1'b1;
        hit_rsp_d = cache_q & hit_q;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      ready_q   <= 1'b0;
      hit_rsp_q <= 1'b0;
      rdata_q   <= '0;
      mreq_q    <= 1'b0;
      mwr_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cache_q   <= 1'b0;
      hit_q     <= 1'b0;
      evict_q   <= 1'b0;
      way_q     <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ready_q   <= ready_d;
      hit_rsp_q <= hit_rsp_d;
      rdata_q   <= rdata_d;
      mreq_q    <= mreq_d;
      mwr_q     <= mwr_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      if (state_q == S_IDLE && core.req_valid) begin
        addr_q  <= core.address[31:2];
        wdata_q <= core.input_data;
        write_q <= core.should_write;
        cache_q <= core.should_cache;
      end
      if (state_q == S_COMPARE) begin
        hit_q   <= hit_any;
        evict_q <= ~free_found;
        way_q   <= hit_any ? hit_way : victim;
      end
      if (state_q == S_REFILL && mem_done && last_word) begin
        valid_q[idx][way_q] <= 1'b1;
        if (evict_q) rr_q[idx] <= rr_next;
      end
    end
  end

  // NOTE: data and tag arrays are not reset; the valid bits alone decide what is resident.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == S_REFILL && mem_done) begin
        data_q[way_q][idx][k_q] <= mem.mem_read_data;
        if (last_word) tag_q[way_q][idx] <= tag;
      end
      if (state_q == S_WRITE && mem_done && cache_q && hit_q)
        data_q[way_q][idx][off] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_l1_set_assoc.sv
// Scoreboard bench for l1_set_assoc: expected responses and memory operations are
// queued when each request is issued and consumed by the response monitor and memory model.
module tb_l1_set_assoc;

  localparam int MEM_LAT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  l1_core_if core_bus ();
  l1_mem_if  mem_bus ();

  l1_set_assoc #(.WAYS(2), .SETS(8), .WORDS_PER_LINE(4)) dut (
    .clock (clock),
    .reset (reset),
    .core  (core_bus),
    .mem   (mem_bus)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] data; logic hit; } rsp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } mop_t;

  rsp_t        rsp_q[$];
  mop_t        mop_q[$];
  logic [31:0] store [logic [31:0]];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Backing memory: unwritten word at byte address a holds 0x9FC0 + a/4 (0x100 -> 0xA000).
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return 32'h0000_9FC0 + (a >> 2);
  endfunction

  task automatic exp_rsp(input logic [31:0] d, input logic h);
    rsp_t e;
    e.data = d;
    e.hit  = h;
    rsp_q.push_back(e);
  endtask

  task automatic exp_mem(input logic wr, input logic [31:0] a, input logic [31:0] d);
    mop_t e;
    e.wr   = wr;
    e.addr = a;
    e.data = d;
    mop_q.push_back(e);
  endtask

  task automatic exp_line(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'h0000_000F;
    for (int i = 0; i < 4; i++) exp_mem(1'b0, base + 32'(4 * i), mem_rd(base + 32'(4 * i)));
  endtask

  // Memory model: completes each request MEM_LAT cycles after it is seen, with a one-cycle mem_ready.
  initial begin
    mop_t e;
    int   cnt;
    cnt = 0;
    mem_bus.mem_ready     = 1'b0;
    mem_bus.mem_read_data = '0;
    forever begin
      @(negedge clock);
      if (reset || mem_bus.mem_ready) begin
        mem_bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_bus.mem_request) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          if (mop_q.size() > 0) e = mop_q.pop_front();
          else e = '{wr: 1'b1, addr: 32'hFFFF_FFFF, data: 32'hFFFF_FFFF};
          check("mem_write", 32'(mem_bus.mem_write), 32'(e.wr));
          check("mem_address", mem_bus.mem_address, e.addr);
          if (mem_bus.mem_write) begin
            check("mem_write_data", mem_bus.mem_write_data, e.data);
            store[mem_bus.mem_address] = mem_bus.mem_write_data;
          end else begin
            mem_bus.mem_read_data = mem_rd(mem_bus.mem_address);
          end
          mem_bus.mem_ready = 1'b1;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (!reset && core_bus.ready) begin
        if (rsp_q.size() > 0) e = rsp_q.pop_front();
        else e = '{data: 32'hFFFF_FFFF, hit: 1'bx};
        check("rsp_data", core_bus.output_data, e.data);
        check("rsp_hit", 32'(core_bus.hit), 32'(e.hit));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic wr, input logic cac);
    @(negedge clock);
    core_bus.address      = a;
    core_bus.input_data   = wd;
    core_bus.should_write = wr;
    core_bus.should_cache = cac;
    core_bus.req_valid    = 1'b1;
    @(posedge clock);
    #1 core_bus.req_valid = 1'b0;
  endtask

  // lat counts the request cycle as 1 and includes the cycle where ready shows.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic cac, output int lat);
    drive(a, wd, wr, cac);
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      lat++;
      #1;
      if (core_bus.ready) break;
    end
    if (!core_bus.ready) check("ready_timeout", 32'(core_bus.ready), 32'd1);
    @(negedge clock);
    #1;
    check("mem_ops_left", 32'(mop_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    core_bus.req_valid    = 1'b0;
    core_bus.address      = '0;
    core_bus.input_data   = '0;
    core_bus.should_write = 1'b0;
    core_bus.should_cache = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(core_bus.ready), 32'd0);
    check("rst_hit", 32'(core_bus.hit), 32'd0);
    check("rst_output_data", core_bus.output_data, 32'd0);
    check("rst_mem_request", 32'(mem_bus.mem_request), 32'd0);
    check("rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
    check("rst_mem_address", mem_bus.mem_address, 32'd0);
    check("rst_mem_write_data", mem_bus.mem_write_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Cold miss refills the whole line, then a hit in two cycles.
    exp_line(32'h100); exp_rsp(32'hA000, 1'b0); do_req(32'h100, 0, 1'b0, 1'b1, lat);
    exp_rsp(32'hA001, 1'b1); do_req(32'h104, 0, 1'b0, 1'b1, lat);
    check("hit_latency", 32'(lat), 32'd2);

    // Set 0 replacement: 0x200 takes free way 1, then the pointer picks way 0, then way 1, then way 0.
    exp_line(32'h200); exp_rsp(32'hA040, 1'b0); do_req(32'h200, 0, 1'b0, 1'b1, lat);
    exp_line(32'h300); exp_rsp(32'hA080, 1'b0); do_req(32'h300, 0, 1'b0, 1'b1, lat);
    exp_rsp(32'hA040, 1'b1); do_req(32'h200, 0, 1'b0, 1'b1, lat);
    exp_line(32'h100); exp_rsp(32'hA000, 1'b0); do_req(32'h100, 0, 1'b0, 1'b1, lat);
    exp_rsp(32'hA080, 1'b1); do_req(32'h300, 0, 1'b0, 1'b1, lat);
    exp_line(32'h200); exp_rsp(32'hA040, 1'b0); do_req(32'h200, 0, 1'b0, 1'b1, lat);
    exp_rsp(32'hA001, 1'b1); do_req(32'h104, 0, 1'b0, 1'b1, lat);

    // Write-through hit updates the line; write miss does not allocate.
    exp_mem(1'b1, 32'h104, 32'hDEAD); exp_rsp(32'h0, 1'b1); do_req(32'h104, 32'hDEAD, 1'b1, 1'b1, lat);
    exp_rsp(32'hDEAD, 1'b1); do_req(32'h104, 0, 1'b0, 1'b1, lat);
    exp_mem(1'b1, 32'h410, 32'hBEEF); exp_rsp(32'h0, 1'b0); do_req(32'h410, 32'hBEEF, 1'b1, 1'b1, lat);
    exp_line(32'h410); exp_rsp(32'hBEEF, 1'b0); do_req(32'h410, 0, 1'b0, 1'b1, lat);

    // Uncached accesses go to memory and leave the resident line untouched.
    exp_mem(1'b0, 32'h100, mem_rd(32'h100)); exp_rsp(32'hA000, 1'b0); do_req(32'h100, 0, 1'b0, 1'b0, lat);
    exp_mem(1'b1, 32'h108, 32'h1234); exp_rsp(32'h0, 1'b0); do_req(32'h108, 32'h1234, 1'b1, 1'b0, lat);
    exp_rsp(32'hA002, 1'b1); do_req(32'h108, 0, 1'b0, 1'b1, lat);
    exp_rsp(32'hDEAD, 1'b1); do_req(32'h104, 0, 1'b0, 1'b1, lat);

    // Reset while the third refill word is outstanding.
    exp_mem(1'b0, 32'h600, mem_rd(32'h600));
    exp_mem(1'b0, 32'h604, mem_rd(32'h604));
    drive(32'h600, 0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (mem_bus.mem_request && mem_bus.mem_address == 32'h608) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("refill_word2_timeout", mem_bus.mem_address, 32'h608);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_mem_request", 32'(mem_bus.mem_request), 32'd0);
    check("rst_mid_ready", 32'(core_bus.ready), 32'd0);
    check("rst_mid_mem_ops_left", 32'(mop_q.size()), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_line(32'h600); exp_rsp(32'hA140, 1'b0); do_req(32'h600, 0, 1'b0, 1'b1, lat);
    exp_line(32'h104); exp_rsp(32'hDEAD, 1'b0); do_req(32'h104, 0, 1'b0, 1'b1, lat);
    exp_rsp(32'hA140, 1'b1); do_req(32'h600, 0, 1'b0, 1'b1, lat);
    check("rsp_left", 32'(rsp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
